// File: rtl/ifu_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch_ctrl_if
// Brief   : Fetch-side bundle: PC generator request, memory port, decode port.
// Revision: 1.0 - initial release
// ============================================================================
interface ifu_fetch_ctrl_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic [XLEN-1:0]     req_pc_i;
    logic                req_valid_i;
    logic                stall_o;
    logic                flush_i;
    logic                mem_req_valid_o;
    logic [XLEN-1:0]     mem_req_addr_o;
    logic                mem_req_ready_i;
    logic                mem_resp_valid_i;
    logic [INST_LEN-1:0] mem_resp_data_i;
    logic                inst_valid_o;
    logic [INST_LEN-1:0] inst_o;
    logic [XLEN-1:0]     inst_pc_o;
    logic                id_ready_i;

    // master: the fetch controller itself
    modport master (
        input  req_pc_i, req_valid_i, flush_i, mem_req_ready_i,
               mem_resp_valid_i, mem_resp_data_i, id_ready_i,
        output stall_o, mem_req_valid_o, mem_req_addr_o,
               inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        output req_pc_i, req_valid_i, flush_i, mem_req_ready_i,
               mem_resp_valid_i, mem_resp_data_i, id_ready_i,
        input  stall_o, mem_req_valid_o, mem_req_addr_o,
               inst_valid_o, inst_o, inst_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch_ctrl
// Brief   : Single-outstanding instruction fetch controller with redirect drop.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ifu_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_drop;
    logic                r_pend_valid;
    logic [XLEN-1:0]     r_pend_pc;
    logic                r_mem_req_valid;
    logic [XLEN-1:0]     r_addr;
    logic                r_inst_valid;
    logic [INST_LEN-1:0] r_inst;
    logic [XLEN-1:0]     r_inst_pc;

    logic                w_accept;
    logic                w_capture;
    logic                w_pend_valid_nxt;
    logic [XLEN-1:0]     w_pend_pc_nxt;

    assign w_accept = (r_state == S_IDLE) ||
                      ((r_state == S_HOLD) && (bus.id_ready_i || bus.flush_i));

    // A redirect arriving while an access is in flight is parked, not stalled
    assign bus.stall_o = bus.req_valid_i && !w_accept && !(bus.flush_i && !r_pend_valid);

    // Redirect target as seen this cycle, including one captured right now
    assign w_capture        = bus.flush_i && bus.req_valid_i;
    assign w_pend_valid_nxt = r_pend_valid || w_capture;
    assign w_pend_pc_nxt    = w_capture ? bus.req_pc_i : r_pend_pc;

    assign bus.mem_req_valid_o = r_mem_req_valid;
    assign bus.mem_req_addr_o  = r_addr;
    assign bus.inst_valid_o    = r_inst_valid;
    assign bus.inst_o          = r_inst;
    assign bus.inst_pc_o       = r_inst_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_drop          <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_pc       <= '0;
            r_mem_req_valid <= 1'b0;
            r_addr          <= '0;
            r_inst_valid    <= 1'b0;
            r_inst          <= '0;
            r_inst_pc       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_addr          <= bus.req_pc_i;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (w_capture) begin
                        r_pend_valid <= 1'b1;
                        r_pend_pc    <= bus.req_pc_i;
                    end
                    if (bus.mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid_i) begin
                        if (r_drop || bus.flush_i) begin
                            // Stale data: discard and chase the redirect if any
                            r_drop       <= 1'b0;
                            r_pend_valid <= 1'b0;
                            if (w_pend_valid_nxt) begin
                                r_addr          <= w_pend_pc_nxt;
                                r_mem_req_valid <= 1'b1;
                                r_state         <= S_REQ;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_inst       <= bus.mem_resp_data_i;
                            r_inst_pc    <= r_addr;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end else begin
                        if (bus.flush_i) begin
                            r_drop <= 1'b1;
                        end
                        if (w_capture) begin
                            r_pend_valid <= 1'b1;
                            r_pend_pc    <= bus.req_pc_i;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.id_ready_i || bus.flush_i) begin
                        r_inst_valid <= 1'b0;
                        if (bus.req_valid_i) begin
                            r_addr          <= bus.req_pc_i;
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_REQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_fetch_ctrl
// Brief   : Directed scenarios plus randomized traffic against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    logic clk;
    logic rst;

    ifu_fetch_ctrl_if #(.XLEN(XLEN), .INST_LEN(INST_LEN)) bus ();

    ifu_fetch_ctrl #(.XLEN(XLEN), .INST_LEN(INST_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level view: what is outstanding, what is held, what is owed
    bit                  m_req;
    logic [XLEN-1:0]     m_req_addr;
    bit                  m_wait;
    bit                  m_hold;
    logic [INST_LEN-1:0] m_inst;
    logic [XLEN-1:0]     m_inst_pc;
    bit                  m_kill;
    logic [XLEN-1:0]     m_redir[$];

    bit hs;
    int dly;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_wait = 0; m_hold = 0; m_kill = 0;
        m_req_addr = '0; m_inst = '0; m_inst_pc = '0;
        m_redir.delete();
    endtask

    task automatic check_outputs();
        bit   idle, acc;
        logic exp_stall;
        idle = !m_req && !m_wait && !m_hold;
        acc  = idle || (m_hold && (bus.id_ready_i || bus.flush_i));
        exp_stall = bus.req_valid_i && !acc && !(bus.flush_i && m_redir.size() == 0);
        chk("stall_o", 64'(bus.stall_o), 64'(exp_stall));
        chk("mem_req_valid_o", 64'(bus.mem_req_valid_o), 64'(m_req));
        if (m_req) chk("mem_req_addr_o", bus.mem_req_addr_o, m_req_addr);
        chk("inst_valid_o", 64'(bus.inst_valid_o), 64'(m_hold));
        if (m_hold) begin
            chk("inst_o", 64'(bus.inst_o), 64'(m_inst));
            chk("inst_pc_o", bus.inst_pc_o, m_inst_pc);
        end
    endtask

    task automatic model_update();
        bit was_hold, idle, acc, busy;
        if (rst) begin
            model_reset();
            return;
        end
        was_hold = m_hold;
        busy     = m_req || m_wait;
        idle     = !busy && !m_hold;
        acc      = idle || (m_hold && (bus.id_ready_i || bus.flush_i));
        if (busy && bus.flush_i) begin
            m_kill = 1;
            if (bus.req_valid_i) begin
                m_redir.delete();
                m_redir.push_back(bus.req_pc_i);
            end
        end
        if (m_req && bus.mem_req_ready_i) begin
            m_req  = 0;
            m_wait = 1;
        end else if (m_wait && bus.mem_resp_valid_i) begin
            m_wait = 0;
            if (m_kill) begin
                m_kill = 0;
                if (m_redir.size() > 0) begin
                    m_req      = 1;
                    m_req_addr = m_redir.pop_front();
                end
            end else begin
                m_hold    = 1;
                m_inst    = bus.mem_resp_data_i;
                m_inst_pc = m_req_addr;
            end
        end
        if (was_hold && (bus.id_ready_i || bus.flush_i)) m_hold = 0;
        if (acc && bus.req_valid_i) begin
            m_req      = 1;
            m_req_addr = bus.req_pc_i;
        end
    endtask

    // One clock: compare mid-cycle, then advance the model over the edge
    task automatic step();
        @(negedge clk);
        check_outputs();
        hs = bus.mem_req_valid_o && bus.mem_req_ready_i;
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic drive_idle();
        bus.req_valid_i      = 0;
        bus.flush_i          = 0;
        bus.mem_req_ready_i  = 0;
        bus.mem_resp_valid_i = 0;
        bus.id_ready_i       = 1;
    endtask

    task automatic stall_is(input string name, input logic exp);
        #1;
        chk(name, 64'(bus.stall_o), 64'(exp));
    endtask

    initial begin
        rst = 1;
        bus.req_pc_i = '0;
        bus.mem_resp_data_i = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset mem_req_valid_o", 64'(bus.mem_req_valid_o), 64'd0);
        chk("reset mem_req_addr_o", bus.mem_req_addr_o, 64'd0);
        chk("reset inst_valid_o", 64'(bus.inst_valid_o), 64'd0);
        chk("reset inst_o", 64'(bus.inst_o), 64'd0);
        chk("reset inst_pc_o", bus.inst_pc_o, 64'd0);
        rst = 0;

        // Basic fetch
        bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0000;
        stall_is("basic stall T", 1'b0);
        step();
        chk("basic req_valid T+1", 64'(bus.mem_req_valid_o), 64'd1);
        chk("basic req_addr T+1", bus.mem_req_addr_o, 64'h8000_0000);
        bus.mem_req_ready_i = 1;
        stall_is("basic stall T+1", 1'b1);
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0013;
        stall_is("basic stall T+2", 1'b1);
        step();
        chk("basic inst_valid T+3", 64'(bus.inst_valid_o), 64'd1);
        chk("basic inst T+3", 64'(bus.inst_o), 64'h13);
        chk("basic inst_pc T+3", bus.inst_pc_o, 64'h8000_0000);
        drive_idle();
        step();

        // Backpressure on both memory and decode
        bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0004; bus.id_ready_i = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp req_valid held", 64'(bus.mem_req_valid_o), 64'd1);
            chk("bp req_addr held", bus.mem_req_addr_o, 64'h8000_0004);
        end
        bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'hABCD_0001;
        step();
        bus.mem_resp_valid_i = 0;
        for (int i = 0; i < 2; i++) begin
            stall_is("bp stall hold", 1'b1);
            step();
            chk("bp inst held", 64'(bus.inst_o), 64'hABCD_0001);
            chk("bp inst_pc held", bus.inst_pc_o, 64'h8000_0004);
        end
        bus.id_ready_i = 1; bus.req_pc_i = 64'h8000_0008;
        stall_is("bp stall release", 1'b0);
        step();
        chk("bp next addr", bus.mem_req_addr_o, 64'h8000_0008);

        // Flush in HOLD
        bus.req_valid_i = 0; bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; bus.id_ready_i = 0;
        bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0008;
        step();
        bus.mem_resp_valid_i = 0;
        chk("hold inst_pc", bus.inst_pc_o, 64'h8000_0008);
        bus.flush_i = 1; bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0300;
        stall_is("hold flush stall", 1'b0);
        step();
        chk("hold flush inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("hold flush addr", bus.mem_req_addr_o, 64'h8000_0300);
        drive_idle(); bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0300;
        step();
        drive_idle();
        step();

        // Flush in WAIT
        bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0004;
        step();
        bus.req_valid_i = 0; bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0;
        bus.flush_i = 1; bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0100;
        stall_is("wait flush stall", 1'b0);
        step();
        drive_idle(); bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'hDEAD_0004;
        step();
        bus.mem_resp_valid_i = 0; bus.mem_req_ready_i = 1;
        chk("wait flush inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("wait flush addr", bus.mem_req_addr_o, 64'h8000_0100);
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0100;
        step();
        chk("wait flush delivered pc", bus.inst_pc_o, 64'h8000_0100);
        drive_idle();
        step();

        // Flush coincident with response
        bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0010;
        step();
        bus.req_valid_i = 0; bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0011;
        bus.flush_i = 1; bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0200;
        step();
        drive_idle();
        chk("coinc inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("coinc addr", bus.mem_req_addr_o, 64'h8000_0200);
        bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0200;
        step();
        drive_idle();
        step();

        // Reset while waiting for a response
        bus.req_valid_i = 1; bus.req_pc_i = 64'h8000_0020;
        step();
        bus.req_valid_i = 0; bus.mem_req_ready_i = 1;
        step();
        bus.mem_req_ready_i = 0; rst = 1;
        step();
        rst = 0; bus.mem_resp_valid_i = 1; bus.mem_resp_data_i = 32'h0000_0077;
        step();
        bus.mem_resp_valid_i = 0;
        chk("rst inst_valid", 64'(bus.inst_valid_o), 64'd0);
        chk("rst mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        bus.req_valid_i = 1;
        stall_is("rst idle accepts", 1'b0);
        bus.req_valid_i = 0;

        // Randomized traffic with an auto-responding memory
        dly = 0;
        hs  = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus.req_pc_i = {$urandom, $urandom};
            bus.flush_i         = ($urandom_range(0, 5) == 0);
            bus.id_ready_i      = ($urandom_range(0, 2) != 0);
            bus.mem_req_ready_i = ($urandom_range(0, 2) != 0);
            bus.mem_resp_valid_i = 0;
            if (hs) dly = $urandom_range(1, 3);
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    bus.mem_resp_valid_i = 1;
                    bus.mem_resp_data_i  = $urandom;
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
